// File: rtl/ram_ctrl_pkg.sv
// Shared widths and request types for the RAM request controller.
package ram_ctrl_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 32;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;

  typedef struct packed {
    logic      we;
    ram_addr_t addr;
    ram_data_t wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_req_ctrl_if.sv
// Request stream, response stream and RAM strobe bundle for ram_req_ctrl.
// slave = controller view, master = client/environment view.
interface ram_req_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  logic              ram_cs_n;
  logic              ram_we_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_cs_n, ram_we_n, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_cs_n, ram_we_n, ram_addr, ram_din
  );

endinterface

// File: rtl/ram_rsp_buf.sv
// In-order response FIFO with any depth >= 1; pointers wrap modulo DEPTH
// so non-power-of-2 depths work. Head is read combinationally so the
// response data is presented in the same cycle the entry becomes valid.
module ram_rsp_buf #(
  parameter  int DEPTH  = 3,
  parameter  int DATA_W = 32,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty;
  // A push into a full buffer is only safe when the head leaves on the same edge.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Entry storage: written at the tail, no reset needed for data.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push+pop leaves count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_valid     = ~w_empty;
  assign o_head_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/ram_req_ctrl.sv
// Valid/ready front-end for a single-port RAM with 1-cycle registered read.
// A read occupies one credit from acceptance until its response is popped,
// so the response buffer can never overflow regardless of rsp_ready.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int RSP_DEPTH = 3
) (
  input logic           clk,
  input logic           rst_n,
  ram_req_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic              r_inflight;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_credit_used;
  logic              w_req_ready;
  logic              w_req_fire;
  logic              w_rsp_valid;
  logic              w_rsp_pop;
  logic [DATA_W-1:0] w_rsp_rdata;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_din;

  // Credits depend only on registered state, so rsp_ready never reaches req_ready.
  assign w_credit_used = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_req_ready   = rst_n & (w_credit_used < (CNT_W + 1)'(RSP_DEPTH));
  assign w_req_fire    = bus.req_valid & w_req_ready;

  // RAM strobes follow the accepted request combinationally.
  assign w_ram_addr   = bus.req_addr;
  assign w_ram_din    = bus.req_wdata;
  assign bus.ram_cs_n = ~w_req_fire;
  assign bus.ram_we_n = ~(w_req_fire & bus.req_we);
  assign bus.ram_addr = w_ram_addr;
  assign bus.ram_din  = w_ram_din;

  // Marks the cycle in which the RAM presents read data for the last accepted read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req_fire & ~bus.req_we;
    end
  end

  assign w_rsp_pop = w_rsp_valid & bus.rsp_ready;

  ram_rsp_buf #(
    .DEPTH  (RSP_DEPTH),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (bus.ram_dout),
    .i_pop       (w_rsp_pop),
    .o_count     (w_count),
    .o_valid     (w_rsp_valid),
    .o_head_data (w_rsp_rdata)
  );

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_rdata;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl: directed scenarios plus a random
// phase, all checked each cycle against a queue-based transaction model.
module tb_ram_req_ctrl;
  import ram_ctrl_pkg::*;

  localparam int RSP_DEPTH = 3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  ram_req_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  ram_req_ctrl #(.ADDR_W(10), .DATA_W(32), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 1024x32 single-port RAM with registered read.
  bit [31:0] ram [1024];
  always @(posedge clk) begin
    if (!bus.ram_cs_n) begin
      if (!bus.ram_we_n) ram[bus.ram_addr] <= bus.ram_din;
      else               bus.ram_dout      <= ram[bus.ram_addr];
    end
  end

  // Reference model state
  bit [31:0]   ref_mem [1024];
  exp_t        exp_q[$];
  int          cyc_now = 0;
  logic [31:0] beats[$];
  int          n_vectors = 0;
  int          n_miscompares = 0;
  int          last_count;
  logic        last_valid;
  logic [31:0] last_rdata;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_now);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic rstn, input logic v, input ram_req_t rq,
                      input logic rr, output logic fired);
    logic exp_ready, exp_valid, exp_fire;
    @(negedge clk);
    rst_n         = rstn;
    bus.req_valid = v;
    bus.req_we    = rq.we;
    bus.req_addr  = rq.addr;
    bus.req_wdata = rq.wdata;
    bus.rsp_ready = rr;
    #1;
    exp_ready = rstn && (exp_q.size() < RSP_DEPTH);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc_now);
    exp_fire  = v && exp_ready;
    check_val("req_ready", bus.req_ready, exp_ready);
    check_val("ram_cs_n", bus.ram_cs_n, !exp_fire);
    check_val("ram_we_n", bus.ram_we_n, !(exp_fire && rq.we));
    if (exp_fire) check_val("ram_addr", bus.ram_addr, rq.addr);
    if (exp_fire && rq.we) check_val("ram_din", bus.ram_din, rq.wdata);
    check_val("rsp_valid", bus.rsp_valid, exp_valid);
    if (exp_valid) check_val("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
    check_val("cnt_bound", (dut.w_count <= RSP_DEPTH), 1'b1);
    last_count = int'(dut.w_count);
    last_valid = bus.rsp_valid;
    last_rdata = bus.rsp_rdata;
    if (bus.rsp_valid && rr) beats.push_back(bus.rsp_rdata);
    @(posedge clk);
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rr) void'(exp_q.pop_front());
      if (exp_fire && rq.we) ref_mem[rq.addr] = rq.wdata;
      else if (exp_fire) exp_q.push_back('{data: ref_mem[rq.addr], cyc: cyc_now});
    end
    cyc_now++;
    fired = exp_fire;
  endtask

  task automatic issue(input logic we, input logic [9:0] a, input logic [31:0] d, input logic rr);
    ram_req_t rq;
    logic f;
    int n;
    rq = '{we: we, addr: a, wdata: d};
    f = 1'b0;
    n = 0;
    while (!f && n < 50) begin
      step(1'b1, 1'b1, rq, rr, f);
      n++;
    end
    check_val("issue_accepted", f, 1'b1);
  endtask

  task automatic idle(input int n, input logic rr);
    ram_req_t rq;
    logic f;
    rq = '{we: 1'b0, addr: 10'h0, wdata: 32'h0};
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, rq, rr, f);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      idle(1, 1'b1);
      n++;
    end
    check_val("drain_empty", exp_q.size(), 0);
    idle(1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_now);
    $fatal(1, "watchdog");
  end

  initial begin
    ram_req_t rq;
    logic f;
    int acc;
    int n;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with a pending request: nothing may be accepted.
    rq = '{we: 1'b1, addr: 10'h001, wdata: 32'h1};
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rq, 1'b1, f);
    idle(1, 1'b1);
    check_val("rst_count", last_count, 0);

    // Write then read back the same word.
    beats.delete();
    issue(1'b1, 10'h155, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 10'h155, 32'h0, 1'b1);
    idle(4, 1'b1);
    check_val("wr_rd_beats", beats.size(), 1);
    check_val("wr_rd_data", (beats.size() > 0) ? beats[0] : 32'h0, 32'hDEADBEEF);

    // Streaming reads at full rate.
    for (int i = 0; i < 8; i++) issue(1'b1, 10'(i), 32'h1000 + 32'(i), 1'b1);
    idle(2, 1'b1);
    beats.delete();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      rq = '{we: 1'b0, addr: 10'(i), wdata: 32'h0};
      step(1'b1, 1'b1, rq, 1'b1, f);
      if (f) acc++;
    end
    idle(4, 1'b1);
    check_val("stream_accepts", acc, 8);
    check_val("stream_beats", beats.size(), 8);
    for (int i = 0; i < 8; i++)
      check_val("stream_data", (beats.size() > i) ? beats[i] : 32'h0, 32'h1000 + 32'(i));

    // Backpressure: only RSP_DEPTH reads fit while the consumer stalls.
    beats.delete();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      rq = '{we: 1'b0, addr: 10'(n), wdata: 32'h0};
      step(1'b1, 1'b1, rq, 1'b0, f);
      if (f) n++;
    end
    check_val("bp_accepted", n, 3);
    check_val("bp_valid_held", last_valid, 1'b1);
    check_val("bp_data_held", last_rdata, 32'h1000);
    acc = 0;
    while (n < 8 && acc < 60) begin
      rq = '{we: 1'b0, addr: 10'(n), wdata: 32'h0};
      step(1'b1, 1'b1, rq, 1'b1, f);
      if (f) n++;
      acc++;
    end
    check_val("bp_all_accepted", n, 8);
    drain();
    check_val("bp_beats", beats.size(), 8);
    for (int i = 0; i < 8; i++)
      check_val("bp_data", (beats.size() > i) ? beats[i] : 32'h0, 32'h1000 + 32'(i));

    // Reset while a read is in flight: its response must vanish.
    beats.delete();
    issue(1'b0, 10'h005, 32'h0, 1'b1);
    rq = '{we: 1'b0, addr: 10'h0, wdata: 32'h0};
    step(1'b0, 1'b0, rq, 1'b1, f);
    idle(1, 1'b1);
    check_val("rst_mid_count", last_count, 0);
    idle(4, 1'b1);
    check_val("rst_mid_beats", beats.size(), 0);

    // Read immediately after a write to the same address.
    beats.delete();
    issue(1'b1, 10'h3FF, 32'hA5A5A5A5, 1'b1);
    issue(1'b0, 10'h3FF, 32'h0, 1'b1);
    idle(4, 1'b1);
    check_val("raw_beats", beats.size(), 1);
    check_val("raw_data", (beats.size() > 0) ? beats[0] : 32'h0, 32'hA5A5A5A5);

    // Random traffic with random backpressure and occasional resets.
    for (int c = 0; c < 400; c++) begin
      logic rstn_r, v_r, rr_r;
      rstn_r = ($urandom_range(0, 63) != 0);
      v_r    = ($urandom_range(0, 2) != 0);
      rr_r   = ($urandom_range(0, 3) != 0);
      rq.we    = ($urandom_range(0, 2) == 0);
      rq.addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
      rq.wdata = $urandom;
      step(rstn_r, v_r, rq, rr_r, f);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
